sram_ctrl_arb: RTL and testbench

Synchronous controller that sequences one asynchronous 32-word SRAM and shares it between two requesters. It runs on one clock and generates CE/OE/WR strobes, address and tri-state write data with cycle-count timing that meets the SRAM access, setup, pulse-width and cycle-time limits. It sits between the pipeline stages that need scratch storage, such as fetch-side and memory-side buffers, and the SRAM instance on the datapath.

---
 rtl/sram_ctrl_arb_if.sv | 39 +++
 rtl/sram_ctrl_arb.sv | 199 +++++++++++++++++++
 tb/tb_sram_ctrl_arb.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_arb_if.sv
// Bus bundle between the two requesters, the SRAM controller and the SRAM pins.
// slave is the controller's view; master is the requester/SRAM environment view.
interface sram_ctrl_arb_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          gnt0;
  logic          gnt1;
  logic          done0;
  logic          done1;
  logic [DW-1:0] rdata;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_dout;
  logic          sram_doe;
  logic [DW-1:0] sram_din;
  logic          sram_ce;
  logic          sram_oe;
  logic          sram_wr;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, sram_din,
    output gnt0, gnt1, done0, done1, rdata,
    output sram_a, sram_dout, sram_doe, sram_ce, sram_oe, sram_wr
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, sram_din,
    input  gnt0, gnt1, done0, done1, rdata,
    input  sram_a, sram_dout, sram_doe, sram_ce, sram_oe, sram_wr
  );
endinterface

// File: rtl/sram_ctrl_arb.sv
// Two-port round-robin controller for an asynchronous SRAM: cycle-counted
// CE/OE/WR sequencing with address, data and CE held for the whole access.
module sram_ctrl_arb #(
  parameter int AW        = 5,
  parameter int DW        = 32,
  parameter int SETUP_CYC = 3,
  parameter int WP_CYC    = 4,
  parameter int RD_CYC    = 7,
  parameter int RECOV_CYC = 2
) (
  input logic           clk,
  input logic           rst,
  sram_ctrl_arb_if.slave bus
);

  localparam int CMAX_A = (SETUP_CYC > WP_CYC) ? SETUP_CYC : WP_CYC;
  localparam int CMAX_B = (RD_CYC > RECOV_CYC) ? RD_CYC : RECOV_CYC;
  localparam int CMAX   = (CMAX_A > CMAX_B) ? CMAX_A : CMAX_B;
  localparam int CW     = (CMAX < 2) ? 1 : $clog2(CMAX);

  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] LD_SETUP  = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] LD_WP     = CW'(WP_CYC - 1);
  localparam logic [CW-1:0] LD_RD     = CW'(RD_CYC - 1);
  localparam logic [CW-1:0] LD_RECOV  = CW'(RECOV_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WSETUP = 3'd1,
    ST_WPULSE = 3'd2,
    ST_WEND   = 3'd3,
    ST_RDWAIT = 3'd4,
    ST_RECOV  = 3'd5
  } state_t;

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic          ptr_r;
  logic          port_r;
  logic          gnt0_r;
  logic          gnt1_r;
  logic          done0_r;
  logic          done1_r;
  logic [DW-1:0] rdata_r;
  logic [AW-1:0] sram_a_r;
  logic [DW-1:0] sram_dout_r;
  logic          sram_doe_r;
  logic          sram_ce_r;
  logic          sram_oe_r;
  logic          sram_wr_r;

  logic          win_s;
  logic          we_s;
  logic [AW-1:0] addr_s;
  logic [DW-1:0] wdata_s;

  // Winner selection and mux of the winning port's request fields
  always_comb begin
    win_s   = 1'b0;
    we_s    = 1'b0;
    addr_s  = {AW{1'b0}};
    wdata_s = {DW{1'b0}};
    if (bus.req0 && bus.req1) begin
      win_s = ptr_r;
    end else if (bus.req1) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
    if (win_s) begin
      we_s    = bus.we1;
      addr_s  = bus.addr1;
      wdata_s = bus.wdata1;
    end else begin
      we_s    = bus.we0;
      addr_s  = bus.addr0;
      wdata_s = bus.wdata0;
    end
  end

  // Transaction sequencer with registered strobes, pulses and read data
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= CNT_ZERO;
      ptr_r       <= 1'b0;
      port_r      <= 1'b0;
      gnt0_r      <= 1'b0;
      gnt1_r      <= 1'b0;
      done0_r     <= 1'b0;
      done1_r     <= 1'b0;
      rdata_r     <= {DW{1'b0}};
      sram_a_r    <= {AW{1'b0}};
      sram_dout_r <= {DW{1'b0}};
      sram_doe_r  <= 1'b0;
      sram_ce_r   <= 1'b1;
      sram_oe_r   <= 1'b1;
      sram_wr_r   <= 1'b1;
    end else begin
      gnt0_r  <= 1'b0;
      gnt1_r  <= 1'b0;
      done0_r <= 1'b0;
      done1_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.req0 || bus.req1) begin
            port_r    <= win_s;
            ptr_r     <= ~win_s;
            gnt0_r    <= ~win_s;
            gnt1_r    <= win_s;
            sram_a_r  <= addr_s;
            sram_ce_r <= 1'b0;
            if (we_s) begin
              sram_dout_r <= wdata_s;
              sram_doe_r  <= 1'b1;
              cnt_r       <= LD_SETUP;
              state_r     <= ST_WSETUP;
            end else begin
              sram_oe_r <= 1'b0;
              cnt_r     <= LD_RD;
              state_r   <= ST_RDWAIT;
            end
          end
        end
        ST_WSETUP: begin
          if (cnt_r == CNT_ZERO) begin
            sram_wr_r <= 1'b0;
            cnt_r     <= LD_WP;
            state_r   <= ST_WPULSE;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        ST_WPULSE: begin
          if (cnt_r == CNT_ZERO) begin
            sram_wr_r <= 1'b1;
            cnt_r     <= CNT_ZERO;
            state_r   <= ST_WEND;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        // WR already high; data stays driven one more cycle for hold margin
        ST_WEND: begin
          sram_ce_r  <= 1'b1;
          sram_doe_r <= 1'b0;
          done0_r    <= ~port_r;
          done1_r    <= port_r;
          cnt_r      <= LD_RECOV;
          state_r    <= ST_RECOV;
        end
        ST_RDWAIT: begin
          if (cnt_r == CNT_ZERO) begin
            rdata_r   <= bus.sram_din;
            sram_ce_r <= 1'b1;
            sram_oe_r <= 1'b1;
            done0_r   <= ~port_r;
            done1_r   <= port_r;
            cnt_r     <= LD_RECOV;
            state_r   <= ST_RECOV;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        // The IDLE cycle that follows is the last turnaround cycle before a grant
        ST_RECOV: begin
          if (cnt_r <= CNT_ONE) begin
            cnt_r   <= CNT_ZERO;
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          cnt_r      <= CNT_ZERO;
          sram_doe_r <= 1'b0;
          sram_ce_r  <= 1'b1;
          sram_oe_r  <= 1'b1;
          sram_wr_r  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.gnt0      = gnt0_r;
  assign bus.gnt1      = gnt1_r;
  assign bus.done0     = done0_r;
  assign bus.done1     = done1_r;
  assign bus.rdata     = rdata_r;
  assign bus.sram_a    = sram_a_r;
  assign bus.sram_dout = sram_dout_r;
  assign bus.sram_doe  = sram_doe_r;
  assign bus.sram_ce   = sram_ce_r;
  assign bus.sram_oe   = sram_oe_r;
  assign bus.sram_wr   = sram_wr_r;

endmodule

// File: tb/tb_sram_ctrl_arb.sv
// Bench for sram_ctrl_arb: behavioural SRAM with access-time model, a
// transaction-level reference model, directed scenarios and random traffic.
module tb_sram_ctrl_arb;

  localparam int SETUP_CYC = 3;
  localparam int WP_CYC    = 4;
  localparam int RD_CYC    = 7;
  localparam int RECOV_CYC = 2;
  localparam int W_LEN     = SETUP_CYC + WP_CYC + 1 + RECOV_CYC;
  localparam int R_LEN     = RD_CYC + RECOV_CYC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  sram_ctrl_arb_if #(.AW(5), .DW(32)) bus ();

  sram_ctrl_arb #(
    .AW(5), .DW(32), .SETUP_CYC(SETUP_CYC), .WP_CYC(WP_CYC),
    .RD_CYC(RD_CYC), .RECOV_CYC(RECOV_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic timeout(input string name);
    n_chk++;
    $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
  endtask

  // Behavioural SRAM: data appears only after the access time has elapsed
  logic [31:0] sram_mem [32];
  int          acc_cnt = 0;
  assign bus.sram_din = (!bus.sram_ce && !bus.sram_oe)
                        ? ((acc_cnt >= RD_CYC - 1) ? sram_mem[bus.sram_a] : ~sram_mem[bus.sram_a])
                        : 32'h5A5A_5A5A;

  always @(posedge clk) begin
    acc_cnt <= (!bus.sram_ce && !bus.sram_oe) ? acc_cnt + 1 : 0;
  end

  // Reference model state: one transaction at a time, timed from its grant edge
  logic [31:0] ref_mem [32];
  logic        ref_ok  [32];
  logic        m_busy = 1'b0, m_we = 1'b0, m_port = 1'b0, m_last = 1'b1;
  int          m_g = 0;
  logic [4:0]  m_addr = 5'd0;
  logic [31:0] m_wdata = 32'd0;
  logic        e_gnt0, e_gnt1, e_done0, e_done1, e_ce, e_oe, e_wr, e_doe, e_rk;
  logic [4:0]  e_a;
  logic [31:0] e_dout, e_rdata;

  always @(posedge clk) begin : ref_model
    int k;
    cyc = cyc + 1;
    e_gnt0 = 1'b0; e_gnt1 = 1'b0; e_done0 = 1'b0; e_done1 = 1'b0;
    if (rst) begin
      if (m_busy && m_we) begin
        k = cyc - m_g;
        if (k > SETUP_CYC && k <= SETUP_CYC + WP_CYC + 1) ref_ok[m_addr] = 1'b0;
      end
      m_busy = 1'b0; m_last = 1'b1;
      e_ce = 1'b1; e_oe = 1'b1; e_wr = 1'b1; e_doe = 1'b0;
      e_a = 5'd0; e_dout = 32'd0; e_rdata = 32'd0; e_rk = 1'b1;
    end else begin
      if (m_busy) begin
        k = cyc - m_g;
        if (k >= (m_we ? W_LEN : R_LEN)) begin
          m_busy = 1'b0;
        end else if (m_we) begin
          if (k == SETUP_CYC) e_wr = 1'b0;
          if (k == SETUP_CYC + WP_CYC) e_wr = 1'b1;
          if (k == SETUP_CYC + WP_CYC + 1) begin
            e_ce = 1'b1; e_doe = 1'b0;
            ref_mem[m_addr] = m_wdata; ref_ok[m_addr] = 1'b1;
            e_done0 = !m_port; e_done1 = m_port;
          end
        end else if (k == RD_CYC) begin
          e_ce = 1'b1; e_oe = 1'b1;
          e_rdata = ref_mem[m_addr]; e_rk = ref_ok[m_addr];
          e_done0 = !m_port; e_done1 = m_port;
        end
      end
      if (!m_busy && (bus.req0 || bus.req1)) begin
        m_port  = (bus.req0 && bus.req1) ? !m_last : bus.req1;
        m_last  = m_port;
        m_busy  = 1'b1;
        m_g     = cyc;
        m_we    = m_port ? bus.we1 : bus.we0;
        m_addr  = m_port ? bus.addr1 : bus.addr0;
        m_wdata = m_port ? bus.wdata1 : bus.wdata0;
        e_a = m_addr; e_ce = 1'b0;
        if (m_we) begin e_dout = m_wdata; e_doe = 1'b1; end
        else e_oe = 1'b0;
        e_gnt0 = !m_port; e_gnt1 = m_port;
      end
    end
  end

  // Per-cycle compare against the model, SRAM pin rules and SRAM write capture
  logic       p_wr = 1'b1, p_ce = 1'b1, p_doe = 1'b0;
  logic [4:0] p_a = 5'd0;
  logic [31:0] p_dout = 32'd0;
  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("ctrl", {56'd0, bus.gnt0, bus.gnt1, bus.done0, bus.done1,
                   bus.sram_ce, bus.sram_oe, bus.sram_wr, bus.sram_doe},
                  {56'd0, e_gnt0, e_gnt1, e_done0, e_done1, e_ce, e_oe, e_wr, e_doe});
      chk("sram_a", {59'd0, bus.sram_a}, {59'd0, e_a});
      chk("sram_dout", {32'd0, bus.sram_dout}, {32'd0, e_dout});
      if (e_rk) chk("rdata", {32'd0, bus.rdata}, {32'd0, e_rdata});
      chk("dio_conflict", {63'd0, bus.sram_doe & ~bus.sram_oe}, 64'd0);
      if (!p_wr && !bus.sram_wr) chk("addr_change_wr_low", {59'd0, bus.sram_a}, {59'd0, p_a});
      if (!p_wr && bus.sram_wr && !p_ce) sram_mem[p_a] <= p_doe ? p_dout : 32'hFFFF_FFFF;
      p_wr <= bus.sram_wr; p_ce <= bus.sram_ce; p_doe <= bus.sram_doe;
      p_a <= bus.sram_a; p_dout <= bus.sram_dout;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic pick(input int sel);
    case (sel)
      0: return bus.gnt0;
      1: return bus.gnt1;
      2: return bus.done0;
      default: return bus.done1;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int budget, input string name, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (pick(sel)) begin at = cyc; break; end
    end
    if (at < 0) timeout(name);
  endtask

  initial begin
    int r, g, g2, d, cnt, wr_first, wr_cnt, doe_seen;
    int gc;
    int gt [4];
    int gp [4];
    for (int i = 0; i < 32; i++) begin
      sram_mem[i] = 32'hA5A5_0000 ^ (32'h0101_0101 * i);
      ref_mem[i]  = sram_mem[i];
      ref_ok[i]   = 1'b1;
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
    bus.addr0 = 5'd0; bus.addr1 = 5'd0; bus.wdata0 = 32'd0; bus.wdata1 = 32'd0;
    for (int i = 0; i < 3; i++) step();
    chk("reset_pins", {56'd0, bus.sram_ce, bus.sram_oe, bus.sram_wr, bus.sram_doe,
                       bus.gnt0, bus.gnt1, bus.done0, bus.done1}, 64'h0000_0000_0000_00E0);
    chk("reset_rdata", {32'd0, bus.rdata}, 64'd0);
    rst = 1'b0;
    step();

    // Port 0 writes 0xDEADBEEF to address 5
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 5'd5; bus.wdata0 = 32'hDEAD_BEEF; r = cyc;
    wait_for(0, 5, "t1_gnt0", g);
    chk("t1_req_to_gnt", 64'(g - r), 64'd1);
    wr_first = -1; wr_cnt = 0; d = -1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (!bus.sram_wr) begin wr_cnt++; if (wr_first < 0) wr_first = cyc; end
      if (bus.done0) d = cyc;
    end
    bus.req0 = 1'b0;
    chk("t1_wr_fall", 64'(wr_first - g), 64'd3);
    chk("t1_wr_width", 64'(wr_cnt), 64'd4);
    chk("t1_done0", 64'(d - g), 64'd8);
    step();
    chk("t1_sram_word5", {32'd0, sram_mem[5]}, 64'h0000_0000_DEAD_BEEF);
    for (int i = 0; i < 3; i++) step();

    // Port 1 reads address 5
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 5'd5;
    wait_for(1, 5, "t2_gnt1", g);
    wait_for(3, 10, "t2_done1", d);
    bus.req1 = 1'b0;
    chk("t2_done1", 64'(d - g), 64'd7);
    chk("t2_rdata", {32'd0, bus.rdata}, 64'h0000_0000_DEAD_BEEF);
    chk("t2_ce_oe", {62'd0, bus.sram_ce, bus.sram_oe}, 64'd3);
    for (int i = 0; i < 4; i++) step();
    chk("t2_rdata_held", {32'd0, bus.rdata}, 64'h0000_0000_DEAD_BEEF);

    // Both ports held: port 0 writes, port 1 reads
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 5'd7; bus.wdata0 = 32'h1357_9BDF;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 5'd5;
    gc = 0;
    for (int i = 0; i < 60 && gc < 4; i++) begin
      step();
      if (bus.gnt0 || bus.gnt1) begin gt[gc] = cyc; gp[gc] = int'(bus.gnt1); gc++; end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    chk("t3_grant_count", 64'(gc), 64'd4);
    if (gc == 4) begin
      chk("t3_order", {60'd0, gp[0][0], gp[1][0], gp[2][0], gp[3][0]}, 64'h5);
      chk("t3_space_wr", 64'(gt[1] - gt[0]), 64'd10);
      chk("t3_space_rd", 64'(gt[2] - gt[1]), 64'd9);
      chk("t3_space_wr2", 64'(gt[3] - gt[2]), 64'd10);
    end
    for (int i = 0; i < 12; i++) step();

    // Reset during the write pulse
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 5'd9; bus.wdata0 = 32'h1234_5678;
    wait_for(0, 5, "t4_gnt0", g);
    for (int i = 0; i < 4; i++) step();
    chk("t4_in_wpulse", {63'd0, bus.sram_wr}, 64'd0);
    rst = 1'b1; bus.req0 = 1'b0;
    step();
    rst = 1'b0;
    chk("t4_strobes", {60'd0, bus.sram_ce, bus.sram_oe, bus.sram_wr, bus.sram_doe}, 64'hE);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin step(); if (bus.done0 || bus.done1) cnt++; end
    chk("t4_no_done", 64'(cnt), 64'd0);
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 5'd5; r = cyc;
    wait_for(1, 5, "t4_gnt1", g);
    chk("t4_idle_latency", 64'(g - r), 64'd1);
    wait_for(3, 10, "t4_done1", d);
    bus.req1 = 1'b0;
    chk("t4_rdata", {32'd0, bus.rdata}, 64'h0000_0000_DEAD_BEEF);
    for (int i = 0; i < 3; i++) step();

    // Port 0 drops its read request one cycle after the grant
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 5'd7;
    wait_for(0, 5, "t5_gnt0", g);
    step();
    bus.req0 = 1'b0;
    wait_for(2, 10, "t5_done0", d);
    chk("t5_done0", 64'(d - g), 64'd7);
    chk("t5_rdata", {32'd0, bus.rdata}, 64'h0000_0000_1357_9BDF);
    cnt = 0;
    for (int i = 0; i < 15; i++) begin step(); if (bus.gnt0 || bus.gnt1) cnt++; end
    chk("t5_no_regrant", 64'(cnt), 64'd0);

    // Write then read-back from one port holding REQ
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 5'd12; bus.wdata0 = 32'hCAFE_F00D;
    wait_for(0, 5, "t6_gnt_wr", g);
    wait_for(2, 12, "t6_done_wr", d);
    bus.we0 = 1'b0;
    wait_for(0, 6, "t6_gnt_rd", g2);
    chk("t6_wr_done", 64'(d - g), 64'd8);
    chk("t6_grant_gap", 64'(g2 - g), 64'd10);
    doe_seen = 0; d = -1;
    for (int i = 0; i < 7; i++) begin
      if (bus.sram_doe) doe_seen++;
      step();
      if (bus.done0) d = cyc;
    end
    bus.req0 = 1'b0;
    chk("t6_doe_in_read", 64'(doe_seen), 64'd0);
    chk("t6_rd_done", 64'(d - g2), 64'd7);
    chk("t6_rdata", {32'd0, bus.rdata}, 64'h0000_0000_CAFE_F00D);
    for (int i = 0; i < 4; i++) step();

    // Random traffic with occasional resets; the compare process does the checking
    for (int c = 0; c < 3000; c++) begin
      step();
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 499) == 0) rst = 1'b1;
      if (bus.req0) begin
        if (bus.done0) begin
          if ($urandom_range(0, 1) == 0) bus.req0 = 1'b0;
          else begin
            bus.we0 = 1'($urandom_range(0, 1)); bus.addr0 = 5'($urandom_range(0, 7));
            bus.wdata0 = $urandom;
          end
        end else if ($urandom_range(0, 19) == 0) bus.req0 = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        bus.req0 = 1'b1; bus.we0 = 1'($urandom_range(0, 1));
        bus.addr0 = 5'($urandom_range(0, 7)); bus.wdata0 = $urandom;
      end
      if (bus.req1) begin
        if (bus.done1) begin
          if ($urandom_range(0, 1) == 0) bus.req1 = 1'b0;
          else begin
            bus.we1 = 1'($urandom_range(0, 1)); bus.addr1 = 5'($urandom_range(0, 7));
            bus.wdata1 = $urandom;
          end
        end else if ($urandom_range(0, 19) == 0) bus.req1 = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        bus.req1 = 1'b1; bus.we1 = 1'($urandom_range(0, 1));
        bus.addr1 = 5'($urandom_range(0, 7)); bus.wdata1 = $urandom;
      end
    end
    rst = 1'b0; bus.req0 = 1'b0; bus.req1 = 1'b0;
    for (int i = 0; i < 15; i++) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
